fetch_decode_fu: RTL and testbench

Front-end and execution slice of the out-of-order RISC-V core. It contains three parts:
- a fetch unit that reads 32-bit words from a flat instruction ROM vector;
- a combinational decoder that produces fields, immediate and control bits for rename/RS/LSQ;
- one single-cycle functional unit (FU) that executes an issued op and broadcasts its result either on the CDB wakeup bus or to the LSQ.

The core instantiates one fetch and one decode path, and three FU copies, one per issue port.

---
 rtl/fetch_decode_fu.sv | 214 +++++++++++++++++++++
 tb/tb_fetch_decode_fu.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_fu.sv
// Front-end fetch, combinational RV32 decoder and one single-cycle issue-port FU.
// Optional macro FU_SRA_EN enables SRA in both the decoder and the FU.
module fetch_decode_fu (
    input  logic          clk,
    input  logic          reset,
    // fetch
    input  logic [31:0]   pc,
    input  logic [31:0]   rom_size,
    input  logic [8191:0] instr_rom,
    output logic [31:0]   instruction,
    output logic          fetch_complete,
    // decode
    output logic [6:0]    opcode,
    output logic [4:0]    rd,
    output logic [4:0]    rs1,
    output logic [4:0]    rs2,
    output logic [2:0]    func3,
    output logic [31:0]   imm,
    output logic          LoadStore,
    output logic          ALUSrc,
    output logic          RegWrite,
    output logic [3:0]    ALUControl,
    output logic          BMS,
    // functional unit
    input  logic          write_enable,
    input  logic [3:0]    fu_alu_control,
    input  logic          fu_alu_src,
    input  logic          is_for_lsq,
    input  logic [31:0]   fu_imm,
    input  logic [31:0]   rs1_value,
    input  logic [31:0]   rs2_value,
    input  logic [5:0]    tag_to_output,
    input  logic [5:0]    rob_index,
    output logic          is_available,
    output logic          wakeup_active,
    output logic [5:0]    wakeup_rob_index,
    output logic [5:0]    wakeup_tag,
    output logic [31:0]   wakeup_value,
    output logic          lsq_wakeup_active,
    output logic [5:0]    lsq_wakeup_rob_index,
    output logic [31:0]   lsq_wakeup_value
);

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_XOR = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_AND = 4'd4;
    localparam logic [3:0] ALU_SRA = 4'd5;

    localparam logic [6:0] OPC_R     = 7'b0110011;
    localparam logic [6:0] OPC_I     = 7'b0010011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;

    // ---------------- fetch ----------------
    logic [31:0] instr_d, instr_q;

    assign fetch_complete = (pc >= rom_size);
    assign instr_d        = fetch_complete ? 32'd0 : instr_rom[{pc[9:2], 5'd0} +: 32];
    assign instruction    = instr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) instr_q <= '0;
        else       instr_q <= instr_d;
    end

    // ---------------- decode ----------------
    logic [6:0] f7;
    logic [2:0] f3;
    logic       dec_ok;

    assign f7 = instruction[31:25];
    assign f3 = instruction[14:12];

    always_comb begin
        opcode     = instruction[6:0];
        func3      = f3;
        dec_ok     = 1'b1;
        rd         = instruction[11:7];
        rs1        = instruction[19:15];
        rs2        = instruction[24:20];
        imm        = '0;
        LoadStore  = 1'b0;
        ALUSrc     = 1'b0;
        RegWrite   = 1'b0;
        ALUControl = ALU_ADD;
        BMS        = 1'b0;
        case (instruction[6:0])
            OPC_R: begin
                RegWrite = 1'b1;
                case ({f7, f3})
                    {7'h00, 3'b000}: ALUControl = ALU_ADD;
                    {7'h20, 3'b000}: ALUControl = ALU_SUB;
                    {7'h00, 3'b100}: ALUControl = ALU_XOR;
                    {7'h00, 3'b110}: ALUControl = ALU_OR;
                    {7'h00, 3'b111}: ALUControl = ALU_AND;
`ifdef FU_SRA_EN
                    {7'h20, 3'b101}: ALUControl = ALU_SRA;
`endif
                    default:         dec_ok = 1'b0;
                endcase
            end
            OPC_I: begin
                imm      = {{20{instruction[31]}}, instruction[31:20]};
                rs2      = '0;
                ALUSrc   = 1'b1;
                RegWrite = 1'b1;
                case (f3)
                    3'b000:  ALUControl = ALU_ADD;
                    3'b100:  ALUControl = ALU_XOR;
                    3'b110:  ALUControl = ALU_OR;
                    3'b111:  ALUControl = ALU_AND;
                    default: dec_ok = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                imm       = {{20{instruction[31]}}, instruction[31:20]};
                rs2       = '0;
                ALUSrc    = 1'b1;
                LoadStore = 1'b1;
                RegWrite  = 1'b1;
                BMS       = (f3 == 3'b100);
                dec_ok    = (f3 == 3'b010) || (f3 == 3'b100);
            end
            OPC_STORE: begin
                imm       = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
                rd        = '0;
                ALUSrc    = 1'b1;
                LoadStore = 1'b1;
                BMS       = (f3 == 3'b000);
                dec_ok    = (f3 == 3'b010) || (f3 == 3'b000);
            end
            OPC_LUI: begin
                imm      = {instruction[31:12], 12'd0};
                rs1      = '0;
                rs2      = '0;
                ALUSrc   = 1'b1;
                RegWrite = 1'b1;
            end
            default: dec_ok = 1'b0;
        endcase
        // Anything not recognised decodes as a harmless bubble.
        if (!dec_ok) begin
            rd         = '0;
            rs1        = '0;
            rs2        = '0;
            imm        = '0;
            LoadStore  = 1'b0;
            ALUSrc     = 1'b0;
            RegWrite   = 1'b0;
            ALUControl = ALU_ADD;
            BMS        = 1'b0;
        end
    end

    // ---------------- functional unit ----------------
    logic [31:0] alu_b, alu_result_d;

    always_comb begin
        alu_b = fu_alu_src ? fu_imm : rs2_value;
        case (fu_alu_control)
            ALU_ADD: alu_result_d = rs1_value + alu_b;
            ALU_SUB: alu_result_d = rs1_value - alu_b;
            ALU_XOR: alu_result_d = rs1_value ^ alu_b;
            ALU_OR:  alu_result_d = rs1_value | alu_b;
            ALU_AND: alu_result_d = rs1_value & alu_b;
`ifdef FU_SRA_EN
            ALU_SRA: alu_result_d = $unsigned($signed(rs1_value) >>> alu_b[4:0]);
`endif
            default: alu_result_d = '0;
        endcase
    end

    logic        wk_active_q, lsq_active_q;
    logic [5:0]  wk_rob_q, wk_tag_q, lsq_rob_q;
    logic [31:0] wk_value_q, lsq_value_q;

    // Active flags pulse for one cycle; payload registers hold between pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wk_active_q  <= 1'b0;
            wk_rob_q     <= '0;
            wk_tag_q     <= '0;
            wk_value_q   <= '0;
            lsq_active_q <= 1'b0;
            lsq_rob_q    <= '0;
            lsq_value_q  <= '0;
        end else begin
            wk_active_q  <= write_enable && !is_for_lsq;
            lsq_active_q <= write_enable && is_for_lsq;
            if (write_enable && !is_for_lsq) begin
                wk_rob_q   <= rob_index;
                wk_tag_q   <= tag_to_output;
                wk_value_q <= alu_result_d;
            end
            if (write_enable && is_for_lsq) begin
                lsq_rob_q   <= rob_index;
                lsq_value_q <= alu_result_d;
            end
        end
    end

    assign is_available         = !reset;
    assign wakeup_active        = wk_active_q;
    assign wakeup_rob_index     = wk_rob_q;
    assign wakeup_tag           = wk_tag_q;
    assign wakeup_value         = wk_value_q;
    assign lsq_wakeup_active    = lsq_active_q;
    assign lsq_wakeup_rob_index = lsq_rob_q;
    assign lsq_wakeup_value     = lsq_value_q;

endmodule

// File: tb/tb_fetch_decode_fu.sv
// Self-checking bench for fetch_decode_fu: directed cases plus randomized fetch/decode/FU traffic.
module tb_fetch_decode_fu;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   pc, rom_size;
    logic [8191:0] instr_rom;
    logic [31:0]   instruction;
    logic          fetch_complete;
    logic [6:0]    opcode;
    logic [4:0]    rd, rs1, rs2;
    logic [2:0]    func3;
    logic [31:0]   imm;
    logic          LoadStore, ALUSrc, RegWrite, BMS;
    logic [3:0]    ALUControl;
    logic          write_enable, fu_alu_src, is_for_lsq;
    logic [3:0]    fu_alu_control;
    logic [31:0]   fu_imm, rs1_value, rs2_value;
    logic [5:0]    tag_to_output, rob_index;
    logic          is_available, wakeup_active, lsq_wakeup_active;
    logic [5:0]    wakeup_rob_index, wakeup_tag, lsq_wakeup_rob_index;
    logic [31:0]   wakeup_value, lsq_wakeup_value;

    int errors = 0;
    int checks = 0;

    fetch_decode_fu dut (
        .clk(clk), .reset(reset), .pc(pc), .rom_size(rom_size), .instr_rom(instr_rom),
        .instruction(instruction), .fetch_complete(fetch_complete),
        .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .func3(func3), .imm(imm),
        .LoadStore(LoadStore), .ALUSrc(ALUSrc), .RegWrite(RegWrite),
        .ALUControl(ALUControl), .BMS(BMS),
        .write_enable(write_enable), .fu_alu_control(fu_alu_control), .fu_alu_src(fu_alu_src),
        .is_for_lsq(is_for_lsq), .fu_imm(fu_imm), .rs1_value(rs1_value), .rs2_value(rs2_value),
        .tag_to_output(tag_to_output), .rob_index(rob_index), .is_available(is_available),
        .wakeup_active(wakeup_active), .wakeup_rob_index(wakeup_rob_index),
        .wakeup_tag(wakeup_tag), .wakeup_value(wakeup_value),
        .lsq_wakeup_active(lsq_wakeup_active), .lsq_wakeup_rob_index(lsq_wakeup_rob_index),
        .lsq_wakeup_value(lsq_wakeup_value)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] dec_pack(input logic [4:0] d, input logic [4:0] s1,
            input logic [4:0] s2, input logic [31:0] im, input logic ls, input logic src,
            input logic rw, input logic [3:0] ctl, input logic bm);
        return {9'd0, d, s1, s2, im, ls, src, rw, ctl, bm};
    endfunction

    function automatic logic [63:0] dec_obs();
        return dec_pack(rd, rs1, rs2, imm, LoadStore, ALUSrc, RegWrite, ALUControl, BMS);
    endfunction

    // Reference ALU from the operation table; SRA built from a logical shift plus sign fill.
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] r;
        case (op)
            4'd0: r = a + b;
            4'd1: r = a + ~b + 32'd1;
            4'd2: r = a ^ b;
            4'd3: r = a | b;
            4'd4: r = a & b;
`ifdef FU_SRA_EN
            4'd5: begin
                r = a >> b[4:0];
                if (a[31]) r = r | ~(32'hFFFF_FFFF >> b[4:0]);
            end
`endif
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    task automatic load_instr(input logic [31:0] w);
        instr_rom[31:0] = w;
        pc = 32'd0;
        rom_size = 32'd4;
        step();
    endtask

    // Builds a random instruction from a chosen semantic kind and the expected decode.
    task automatic gen_dec(output logic [31:0] w, output logic [63:0] exp);
        logic [4:0]  d, s1, s2;
        logic [11:0] i12;
        logic [19:0] i20;
        logic [31:0] sx;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [3:0]  ctl;
        logic        b, ok;
        int          sel;
        d = 5'($urandom); s1 = 5'($urandom); s2 = 5'($urandom);
        i12 = 12'($urandom); i20 = 20'($urandom);
        sx = {{20{i12[11]}}, i12};
        b = 1'($urandom);
        exp = '0;
        case ($urandom_range(0, 8))
            0: begin
                sel = $urandom_range(0, 5);
                ok = 1'b1;
                case (sel)
                    0: begin f3 = 3'd0; f7 = 7'h00; ctl = 4'd0; end
                    1: begin f3 = 3'd0; f7 = 7'h20; ctl = 4'd1; end
                    2: begin f3 = 3'd4; f7 = 7'h00; ctl = 4'd2; end
                    3: begin f3 = 3'd6; f7 = 7'h00; ctl = 4'd3; end
                    4: begin f3 = 3'd7; f7 = 7'h00; ctl = 4'd4; end
                    default: begin
                        f3 = 3'd5; f7 = 7'h20; ctl = 4'd5;
`ifndef FU_SRA_EN
                        ok = 1'b0;
`endif
                    end
                endcase
                w = {f7, s2, s1, f3, d, 7'h33};
                if (ok) exp = dec_pack(d, s1, s2, 32'd0, 1'b0, 1'b0, 1'b1, ctl, 1'b0);
            end
            1: begin
                case ($urandom_range(0, 3))
                    0: begin f3 = 3'd0; ctl = 4'd0; end
                    1: begin f3 = 3'd4; ctl = 4'd2; end
                    2: begin f3 = 3'd6; ctl = 4'd3; end
                    default: begin f3 = 3'd7; ctl = 4'd4; end
                endcase
                w = {i12, s1, f3, d, 7'h13};
                exp = dec_pack(d, s1, 5'd0, sx, 1'b0, 1'b1, 1'b1, ctl, 1'b0);
            end
            2: begin
                w = {i12, s1, (b ? 3'd4 : 3'd2), d, 7'h03};
                exp = dec_pack(d, s1, 5'd0, sx, 1'b1, 1'b1, 1'b1, 4'd0, b);
            end
            3: begin
                w = {i12[11:5], s2, s1, (b ? 3'd0 : 3'd2), i12[4:0], 7'h23};
                exp = dec_pack(5'd0, s1, s2, sx, 1'b1, 1'b1, 1'b0, 4'd0, b);
            end
            4: begin
                w = {i20, d, 7'h37};
                exp = dec_pack(d, 5'd0, 5'd0, {i20, 12'd0}, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0);
            end
            5: w = {7'h01, s2, s1, 3'($urandom), d, 7'h33};
            6: begin
                case ($urandom_range(0, 3))
                    0: f3 = 3'd1;
                    1: f3 = 3'd2;
                    2: f3 = 3'd3;
                    default: f3 = 3'd5;
                endcase
                w = {i12, s1, f3, d, 7'h13};
            end
            7: w = b ? {i12, s1, 3'd0, d, 7'h03} : {i12[11:5], s2, s1, 3'd1, i12[4:0], 7'h23};
            default: w = {i12, s1, 3'($urandom), d, (b ? 7'h63 : 7'h6F)};
        endcase
    endtask

    initial begin
        logic [31:0] w, sra_exp, res;
        logic [63:0] e;
        logic        e_wa, e_la;
        logic [5:0]  e_wrob, e_wtag, e_lrob;
        logic [31:0] e_wval, e_lval;

        reset = 1'b1;
        pc = '0; rom_size = '0; instr_rom = '0;
        write_enable = 1'b0; fu_alu_control = '0; fu_alu_src = 1'b0; is_for_lsq = 1'b0;
        fu_imm = '0; rs1_value = '0; rs2_value = '0; tag_to_output = '0; rob_index = '0;
        for (int k = 0; k < 256; k++) instr_rom[k*32 +: 32] = $urandom;
        #3;
        check("reset_instr", instruction, 32'd0);
        check("reset_active", {wakeup_active, lsq_wakeup_active, is_available}, 3'b000);
        check("reset_payload", {wakeup_rob_index, wakeup_tag, lsq_wakeup_rob_index,
              wakeup_value ^ lsq_wakeup_value}, 50'd0);
        check("romsize0_complete", fetch_complete, 1'b1);
        step();
        reset = 1'b0;
        #1;
        check("avail_after_reset", is_available, 1'b1);
        step();
        check("romsize0_instr", instruction, 32'd0);

        // Directed fetch sequence
        instr_rom[31:0] = 32'h00A00293;
        rom_size = 32'd4; pc = 32'd0;
        #1;
        check("fetch_pc0_complete", fetch_complete, 1'b0);
        step();
        check("fetch_word0", instruction, 32'h00A00293);
        check("dec_addi", dec_obs(), dec_pack(5'd5, 5'd0, 5'd0, 32'd10, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0));
        pc = 32'd4;
        #1;
        check("fetch_pc4_complete", fetch_complete, 1'b1);
        step();
        check("fetch_past_end", instruction, 32'd0);

        // Randomized fetch against a word-array view of the ROM
        for (int n = 0; n < 24; n++) begin
            rom_size = 32'($urandom_range(0, 1100));
            pc = 32'($urandom_range(0, 1100));
            step();
            w = (pc < rom_size) ? instr_rom[((pc / 4) % 256) * 32 +: 32] : 32'd0;
            check("fetch_rand", instruction, w);
            check("fetch_rand_complete", fetch_complete, (pc >= rom_size));
        end

        // Directed decode
        load_instr(32'h00528333);
        check("dec_add", dec_obs(), dec_pack(5'd6, 5'd5, 5'd5, 32'd0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0));
        load_instr(32'h0062A423);
        check("dec_sw", dec_obs(), dec_pack(5'd0, 5'd5, 5'd6, 32'd8, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0));
        load_instr(32'h123453B7);
        check("dec_lui", dec_obs(), dec_pack(5'd7, 5'd0, 5'd0, 32'h12345000, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0));
        load_instr(32'h40535433);
`ifdef FU_SRA_EN
        check("dec_sra", dec_obs(), dec_pack(5'd8, 5'd6, 5'd5, 32'd0, 1'b0, 1'b0, 1'b1, 4'd5, 1'b0));
`else
        check("dec_sra_off", dec_obs(), 64'd0);
`endif
        load_instr(32'h00000000);
        check("dec_zero", dec_obs(), 64'd0);

        // Randomized decode
        for (int n = 0; n < 60; n++) begin
            gen_dec(w, e);
            load_instr(w);
            check("dec_rand", dec_obs(), e);
            check("dec_rand_raw", {opcode, func3}, {w[6:0], w[14:12]});
        end

        // FU: SUB with tag/rob, one-cycle pulse, payload hold
        write_enable = 1'b1; fu_alu_control = 4'd1; fu_alu_src = 1'b0; is_for_lsq = 1'b0;
        rs1_value = 32'd7; rs2_value = 32'd9; tag_to_output = 6'd12; rob_index = 6'd3;
        step();
        check("fu_sub", {wakeup_active, lsq_wakeup_active, wakeup_tag, wakeup_rob_index, wakeup_value},
              {2'b10, 6'd12, 6'd3, 32'hFFFFFFFE});
        write_enable = 1'b0;
        step();
        check("fu_sub_pulse_end", {wakeup_active, wakeup_value}, {1'b0, 32'hFFFFFFFE});

        // FU: SRA
`ifdef FU_SRA_EN
        sra_exp = 32'hFFFFFFF0;
`else
        sra_exp = 32'd0;
`endif
        write_enable = 1'b1; fu_alu_control = 4'd5; rs1_value = 32'hFFFFFF00; rs2_value = 32'd4;
        tag_to_output = 6'd1; rob_index = 6'd2;
        step();
        check("fu_sra", {wakeup_active, wakeup_value}, {1'b1, sra_exp});

        // FU: LSQ address (back-to-back with the SRA issue)
        fu_alu_control = 4'd0; is_for_lsq = 1'b1; rs1_value = 32'h100; fu_alu_src = 1'b1;
        fu_imm = 32'd8; rob_index = 6'd5;
        step();
        check("fu_lsq", {wakeup_active, lsq_wakeup_active, lsq_wakeup_rob_index, lsq_wakeup_value},
              {2'b01, 6'd5, 32'h108});

        // Randomized back-to-back FU traffic against the broadcast model
        e_wa = 1'b0; e_la = 1'b1; e_wrob = 6'd2; e_wtag = 6'd1; e_wval = sra_exp;
        e_lrob = 6'd5; e_lval = 32'h108;
        for (int n = 0; n < 60; n++) begin
            write_enable = ($urandom_range(0, 3) != 0);
            fu_alu_control = 4'($urandom_range(0, 7));
            fu_alu_src = 1'($urandom); is_for_lsq = 1'($urandom);
            fu_imm = $urandom; rs1_value = $urandom; rs2_value = $urandom;
            if (n % 5 == 0) rs1_value[31] = 1'b1;
            tag_to_output = 6'($urandom); rob_index = 6'($urandom);
            res = ref_alu(fu_alu_control, rs1_value, fu_alu_src ? fu_imm : rs2_value);
            e_wa = write_enable && !is_for_lsq;
            e_la = write_enable && is_for_lsq;
            if (e_wa) begin e_wrob = rob_index; e_wtag = tag_to_output; e_wval = res; end
            if (e_la) begin e_lrob = rob_index; e_lval = res; end
            step();
            check("fu_rand_ctl", {wakeup_active, lsq_wakeup_active, wakeup_rob_index, wakeup_tag,
                  lsq_wakeup_rob_index}, {e_wa, e_la, e_wrob, e_wtag, e_lrob});
            check("fu_rand_val", {wakeup_value, lsq_wakeup_value}, {e_wval, e_lval});
        end

        // Reset while a result is on the bus
        write_enable = 1'b1; is_for_lsq = 1'b0; fu_alu_control = 4'd0; fu_alu_src = 1'b0;
        rs1_value = 32'd1; rs2_value = 32'd2; tag_to_output = 6'd9; rob_index = 6'd9;
        step();
        check("pending_before_reset", {wakeup_active, wakeup_value}, {1'b1, 32'd3});
        reset = 1'b1;
        #1;
        check("midreset_active", {wakeup_active, lsq_wakeup_active, is_available}, 3'b000);
        check("midreset_payload", {wakeup_value, lsq_wakeup_value, wakeup_tag}, 70'd0);
        write_enable = 1'b0;
        step();
        reset = 1'b0;
        #1;
        check("avail_after_midreset", is_available, 1'b1);
        step();
        check("no_broadcast_after_reset", {wakeup_active, lsq_wakeup_active}, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
